ehl_clock_gate: RTL and testbench



---
 rtl/ehl_clock_gate.sv | 85 ++++++++
 tb/tb_ehl_clock_gate.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ehl_clock_gate.sv
// Latch-based, glitch-free integrated clock gate with a scan override.
// TECHNOLOGY=1 builds it from discrete cells; any other value uses the behavioural model.

module ehl_cg_latch (
  input  logic clk_i,
  input  logic clr_n_i,
  input  logic d_i,
  output logic q_o
);
  // Transparent while the clock is low; the async clear wins over transparency.
  always_latch begin
    if (!clr_n_i) begin
      q_o <= 1'b0;
    end else if (!clk_i) begin
      q_o <= d_i;
    end
  end
endmodule

module ehl_cg_or2 (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i | b_i;
endmodule

module ehl_cg_and2 (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i & b_i;
endmodule

module ehl_clock_gate #(
  parameter int TECHNOLOGY = 0
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic test_mode,
  input  logic enable,
  output logic clk_out
);

  generate
    if (TECHNOLOGY == 1) begin : g_struct
      logic en_d;
      logic en_lat;

      ehl_cg_or2 u_or (
        .a_i (enable),
        .b_i (test_mode),
        .y_o (en_d)
      );

      ehl_cg_latch u_lat (
        .clk_i   (clk_in),
        .clr_n_i (reset_n),
        .d_i     (en_d),
        .q_o     (en_lat)
      );

      ehl_cg_and2 u_and (
        .a_i (clk_in),
        .b_i (en_lat),
        .y_o (clk_out)
      );
    end else begin : g_behav
      logic en_lat;

      // Enable is captured only in the low phase, so the AND can never chop a high pulse.
      always_latch begin
        if (!reset_n) begin
          en_lat <= 1'b0;
        end else if (!clk_in) begin
          en_lat <= enable | test_mode;
        end
      end

      assign clk_out = clk_in & en_lat;
    end
  endgenerate

endmodule

// File: tb/tb_ehl_clock_gate.sv
// Bench for ehl_clock_gate: behavioural, structural and fallback instances checked
// against a phase-level model of the gate, with directed and randomized enable traffic.

module tb_ehl_clock_gate;

  logic clkIn = 1'b0;
  logic resetN = 1'b0;
  logic testMode = 1'b1;
  logic enable = 1'b1;
  logic clkOut0;
  logic clkOut1;
  logic clkOutFb;

  int checkCount = 0;
  int passCount = 0;
  int glitchCount = 0;
  bit checkEnable = 1'b1;

  bit pat [15] = '{1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0};

  ehl_clock_gate #(.TECHNOLOGY(0)) uBehav (
    .clk_in    (clkIn),
    .reset_n   (resetN),
    .test_mode (testMode),
    .enable    (enable),
    .clk_out   (clkOut0)
  );

  ehl_clock_gate #(.TECHNOLOGY(1)) uStruct (
    .clk_in    (clkIn),
    .reset_n   (resetN),
    .test_mode (testMode),
    .enable    (enable),
    .clk_out   (clkOut1)
  );

  ehl_clock_gate #(.TECHNOLOGY(5)) uFallback (
    .clk_in    (clkIn),
    .reset_n   (resetN),
    .test_mode (testMode),
    .enable    (enable),
    .clk_out   (clkOutFb)
  );

  always #10 clkIn = ~clkIn;

  // Reference model: a high phase is open iff, at the end of the preceding low
  // phase, reset was released and enable|test_mode was 1; a reset closes it at once.
  logic sampledGate = 1'b0;
  logic modelGate = 1'b0;

  always @(negedge clkIn) begin
    #9;
    sampledGate = resetN & (enable | testMode);
  end

  always @(posedge clkIn) modelGate = sampledGate;

  always @(negedge resetN) modelGate = 1'b0;

  // Clock edges fall on multiples of 10; any gated-clock change elsewhere is a glitch.
  always @(clkOut0 or clkOut1 or clkOutFb) begin
    if (($time % 10) != 0) glitchCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end else begin
      passCount++;
    end
  endtask

  task automatic compareAll(input string when);
    logic expOut;
    expOut = clkIn & modelGate & resetN;
    checkOutput({"tech0 ", when}, {31'b0, clkOut0}, {31'b0, expOut});
    checkOutput({"tech1 ", when}, {31'b0, clkOut1}, {31'b0, expOut});
    checkOutput({"fallback ", when}, {31'b0, clkOutFb}, {31'b0, expOut});
  endtask

  // Sample just after every edge and again mid-phase.
  always @(clkIn) begin
    if (checkEnable) begin
      #1 compareAll("edge+1");
      #4 compareAll("edge+5");
    end
  end

  // mode: 0 negedge-aligned, 1 posedge-aligned, 2 negedge+2, 3 posedge+2
  task automatic applyStimulus(input int mode);
    for (int i = 0; i < 15; i++) begin
      if ((mode % 2) == 0) @(negedge clkIn);
      else @(posedge clkIn);
      if (mode >= 2) #2;
      enable = pat[i];
    end
    @(negedge clkIn);
    enable = 1'b0;
    repeat (2) @(posedge clkIn);
  endtask

  initial begin
    $display("[TB] reset held with enable=1, test_mode=1");
    repeat (5) @(posedge clkIn);
    resetN = 1'b1;
    repeat (2) @(posedge clkIn);
    #1 checkOutput("reset release open", {31'b0, clkOut0}, 32'd1);

    @(negedge clkIn);
    testMode = 1'b0;
    enable = 1'b0;
    repeat (2) @(posedge clkIn);

    for (int m = 0; m < 4; m++) begin
      $display("[TB] enable pattern, mode %0d", m);
      applyStimulus(m);
    end

    $display("[TB] test_mode override");
    @(negedge clkIn);
    testMode = 1'b1;
    enable = 1'b0;
    repeat (4) @(posedge clkIn);
    #5 testMode = 1'b0;
    #4 checkOutput("test_mode drop full pulse", {31'b0, clkOut1}, 32'd1);
    @(posedge clkIn);
    #3 checkOutput("test_mode drop closed", {31'b0, clkOut0}, 32'd0);

    $display("[TB] randomized traffic");
    for (int p = 0; p < 60; p++) begin
      @(negedge clkIn);
      #($urandom_range(1, 6));
      enable = 1'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        resetN = 1'b0;
        #1 resetN = 1'b1;
      end
      @(posedge clkIn);
      #($urandom_range(1, 8));
      enable = 1'($urandom);
      if ($urandom_range(0, 7) == 0) testMode = ~testMode;
    end

    @(negedge clkIn);
    #6;
    checkEnable = 1'b0;
    checkOutput("glitch count", glitchCount, 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
